// File: rtl/color_stabilizer_if.sv
// Bundle between the color comparator / event consumer (master) and color_stabilizer (slave).
interface color_stabilizer_if;
  logic       sample_valid;
  logic       red;
  logic       green;
  logic       blue;
  logic       purple;
  logic       yellow;
  logic [2:0] stable_code;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;
  logic       evt_ovf;

  modport master (
    output sample_valid, red, green, blue, purple, yellow, evt_ready,
    input  stable_code, evt_valid, evt_code, evt_ovf
  );

  modport slave (
    input  sample_valid, red, green, blue, purple, yellow, evt_ready,
    output stable_code, evt_valid, evt_code, evt_ovf
  );
endinterface

// File: rtl/color_stabilizer.sv
// Debounces comparator color flags into a committed 3-bit class and raises a valid/ready event per commit.
// Optional macro COLOR_STAB_NONE_EVT_EN: when defined, commits to NONE also raise events.
module color_stabilizer #(
  parameter int HOLD_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  color_stabilizer_if.slave  bus
);

  localparam logic [2:0] CLS_NONE   = 3'd0;
  localparam logic [2:0] CLS_RED    = 3'd1;
  localparam logic [2:0] CLS_GREEN  = 3'd2;
  localparam logic [2:0] CLS_BLUE   = 3'd3;
  localparam logic [2:0] CLS_PURPLE = 3'd4;
  localparam logic [2:0] CLS_YELLOW = 3'd5;
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_COUNT);

  typedef enum logic {ST_STABLE, ST_TRACK} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       cand_reg, cand_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       stable_reg, stable_next;
  logic             evt_valid_reg, evt_valid_next;
  logic [2:0]       evt_code_reg, evt_code_next;
  logic             evt_ovf_reg, evt_ovf_next;

  logic [2:0]       cls;
  logic [CNT_W-1:0] run_len;
  logic             commit;
  logic             evt_fire;

  always_comb begin
    if (bus.yellow)      cls = CLS_YELLOW;
    else if (bus.purple) cls = CLS_PURPLE;
    else if (bus.red)    cls = CLS_RED;
    else if (bus.green)  cls = CLS_GREEN;
    else if (bus.blue)   cls = CLS_BLUE;
    else                 cls = CLS_NONE;
  end

  always_comb begin
    state_next     = state_reg;
    cand_next      = cand_reg;
    cnt_next       = cnt_reg;
    stable_next    = stable_reg;
    evt_valid_next = evt_valid_reg;
    evt_code_next  = evt_code_reg;
    evt_ovf_next   = evt_ovf_reg;
    run_len        = '0;
    commit         = 1'b0;
    evt_fire       = 1'b0;

    if (bus.sample_valid) begin
      if (cls == stable_reg) begin
        state_next = ST_STABLE;
        cnt_next   = '0;
      end else begin
        // A new or different candidate restarts the run at one sample.
        if (state_reg == ST_STABLE || cls != cand_reg) run_len = CNT_W'(1);
        else                                           run_len = cnt_reg + 1'b1;
        cand_next = cls;
        if (run_len == HOLD_C) begin
          commit      = 1'b1;
          stable_next = cls;
          state_next  = ST_STABLE;
          cnt_next    = '0;
        end else begin
          state_next = ST_TRACK;
          cnt_next   = run_len;
        end
      end
    end

`ifdef COLOR_STAB_NONE_EVT_EN
    evt_fire = commit;
`else
    evt_fire = commit && (cand_next != CLS_NONE);
`endif

    if (evt_fire) begin
      // A pending event being accepted this cycle frees the slot for the new one.
      if (!evt_valid_reg || bus.evt_ready) begin
        evt_valid_next = 1'b1;
        evt_code_next  = cand_next;
      end else begin
        evt_ovf_next = 1'b1;
      end
    end else if (evt_valid_reg && bus.evt_ready) begin
      evt_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_STABLE;
      cand_reg      <= CLS_NONE;
      cnt_reg       <= '0;
      stable_reg    <= CLS_NONE;
      evt_valid_reg <= 1'b0;
      evt_code_reg  <= CLS_NONE;
      evt_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      stable_reg    <= stable_next;
      evt_valid_reg <= evt_valid_next;
      evt_code_reg  <= evt_code_next;
      evt_ovf_reg   <= evt_ovf_next;
    end
  end

  assign bus.stable_code = stable_reg;
  assign bus.evt_valid   = evt_valid_reg;
  assign bus.evt_code    = evt_code_reg;
  assign bus.evt_ovf     = evt_ovf_reg;

endmodule

// File: tb/tb_color_stabilizer.sv
// Self-checking bench for color_stabilizer: directed vector table plus randomized run against a run-history model.
module tb_color_stabilizer;

  localparam int H = 4;
`ifdef COLOR_STAB_NONE_EVT_EN
  localparam bit NONE_EVT = 1'b1;
`else
  localparam bit NONE_EVT = 1'b0;
`endif

  // flags packing: {red, green, blue, purple, yellow}
  localparam logic [4:0] F_0 = 5'b00000;
  localparam logic [4:0] F_R = 5'b10000;
  localparam logic [4:0] F_G = 5'b01000;
  localparam logic [4:0] F_B = 5'b00100;
  localparam logic [4:0] F_P = 5'b00010;
  localparam logic [4:0] F_Y = 5'b00001;

  typedef struct {
    logic       rst;
    logic       sv;
    logic [4:0] flags;
    logic       rdy;
    logic [2:0] e_stable;
    logic       e_valid;
    logic [2:0] e_code;
    logic       e_ovf;
  } vec_t;

  logic clk;
  logic rst;
  color_stabilizer_if sif ();

  color_stabilizer #(.HOLD_COUNT(H), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  vec_t vecs[$];

  // reference model state
  logic [2:0] m_stable;
  logic       m_valid;
  logic [2:0] m_code;
  logic       m_ovf;
  int         hist[$];

  function automatic void add(input logic r, input logic sv, input logic [4:0] f, input logic rdy,
                              input logic [2:0] es, input logic ev, input logic [2:0] ec, input logic eo);
    vec_t v;
    v.rst = r; v.sv = sv; v.flags = f; v.rdy = rdy;
    v.e_stable = es; v.e_valid = ev; v.e_code = ec; v.e_ovf = eo;
    vecs.push_back(v);
  endfunction

  function automatic int classify(input logic [4:0] f);
    if (f[0]) return 5;
    if (f[1]) return 4;
    if (f[4]) return 1;
    if (f[3]) return 2;
    if (f[2]) return 3;
    return 0;
  endfunction

  // Commit when the last H valid samples since the previous commit all name the same non-stable class.
  function automatic void model_step(input logic r, input logic sv, input logic [4:0] f, input logic rdy);
    int  c;
    bit  commit;
    bit  all_same;
    if (r) begin
      m_stable = 0; m_valid = 0; m_code = 0; m_ovf = 0;
      hist.delete();
      return;
    end
    commit = 0;
    c = classify(f);
    if (sv) begin
      if (c == int'(m_stable)) hist.delete();
      else begin
        hist.push_back(c);
        if (hist.size() > H) void'(hist.pop_front());
        all_same = (hist.size() == H);
        foreach (hist[i]) if (hist[i] != c) all_same = 0;
        if (all_same) begin
          commit = 1;
          m_stable = 3'(c);
          hist.delete();
        end
      end
    end
    if (commit && (NONE_EVT || c != 0)) begin
      if (!m_valid || rdy) begin
        m_valid = 1;
        m_code  = 3'(c);
      end else m_ovf = 1;
    end else if (m_valid && rdy) m_valid = 0;
  endfunction

  task automatic drive(input logic r, input logic sv, input logic [4:0] f, input logic rdy);
    rst              = r;
    sif.sample_valid = sv;
    {sif.red, sif.green, sif.blue, sif.purple, sif.yellow} = f;
    sif.evt_ready    = rdy;
  endtask

  task automatic check(input string name, input logic [2:0] es, input logic ev,
                       input logic [2:0] ec, input logic eo);
    total_cnt++;
    if (sif.stable_code === es && sif.evt_valid === ev && sif.evt_code === ec && sif.evt_ovf === eo)
      pass_cnt++;
    else
      $display("FAIL %s: got stable=%0d valid=%0b code=%0d ovf=%0b, want stable=%0d valid=%0b code=%0d ovf=%0b",
               name, sif.stable_code, sif.evt_valid, sif.evt_code, sif.evt_ovf, es, ev, ec, eo);
  endtask

  initial begin
    logic [4:0] f;
    logic       r, sv, rdy;

    // Seq A: basic commit, one-cycle event
    add(1,0,F_0,1, 0,0,0,0);
    add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0);
    add(0,1,F_R,1, 1,1,1,0);
    add(0,0,F_0,1, 1,0,1,0);
    // Seq B: interrupted run, then commit
    add(1,0,F_0,1, 0,0,0,0);
    add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0);
    add(0,1,F_G,1, 0,0,0,0);
    add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0);
    add(0,1,F_R,1, 1,1,1,0);
    add(0,0,F_0,1, 1,0,1,0);
    // Seq C: priority; gaps without strobe do not break the run
    add(1,0,F_0,1, 0,0,0,0);
    add(0,1,F_R|F_G|F_Y,1, 0,0,0,0); add(0,0,F_B,1, 0,0,0,0);
    add(0,1,F_R|F_G|F_Y,1, 0,0,0,0); add(0,1,F_R|F_G|F_Y,1, 0,0,0,0);
    add(0,1,F_R|F_G|F_Y,1, 5,1,5,0);
    add(0,0,F_0,1, 5,0,5,0);
    add(0,1,F_P|F_R,1, 5,0,5,0); add(0,1,F_P|F_R,1, 5,0,5,0); add(0,1,F_P|F_R,1, 5,0,5,0);
    add(0,1,F_P|F_R,1, 4,1,4,0);
    add(0,0,F_0,1, 4,0,4,0);
    // Seq D: overflow while event stalled
    add(1,0,F_0,0, 0,0,0,0);
    add(0,1,F_R,0, 0,0,0,0); add(0,1,F_R,0, 0,0,0,0); add(0,1,F_R,0, 0,0,0,0);
    add(0,1,F_R,0, 1,1,1,0);
    add(0,1,F_G,0, 1,1,1,0); add(0,1,F_G,0, 1,1,1,0); add(0,1,F_G,0, 1,1,1,0);
    add(0,1,F_G,0, 2,1,1,1);
    add(0,0,F_0,1, 2,0,1,1);
    add(0,0,F_0,0, 2,0,1,1);
    // Seq E: reset mid-run discards run and beats a strobe
    add(1,0,F_0,1, 0,0,0,0);
    add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0);
    add(1,1,F_R,1, 0,0,0,0);
    add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0); add(0,1,F_R,1, 0,0,0,0);
    add(0,1,F_R,1, 1,1,1,0);
    // Seq F: commit back to NONE
    add(0,0,F_0,1, 1,0,1,0);
    add(0,1,F_0,1, 1,0,1,0); add(0,1,F_0,1, 1,0,1,0); add(0,1,F_0,1, 1,0,1,0);
    add(0,1,F_0,1, 0,NONE_EVT,NONE_EVT ? 3'd0 : 3'd1,0);
    add(0,0,F_0,1, 0,0,NONE_EVT ? 3'd0 : 3'd1,0);

    drive(1, 0, F_0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sv, vecs[i].flags, vecs[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_stable, vecs[i].e_valid, vecs[i].e_code, vecs[i].e_ovf);
    end

    // Randomized run against the model; flags tend to repeat so runs reach HOLD_COUNT.
    f = F_0;
    for (int n = 0; n < 3000; n++) begin
      r   = (n == 0) || ($urandom_range(0, 299) == 0);
      sv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 3) f = 5'($urandom & $urandom & $urandom);
      drive(r, sv, f, rdy);
      model_step(r, sv, f, rdy);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", n), m_stable, m_valid, m_code, m_ovf);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
